// File: rtl/left_shift_sequencer.sv
// Multi-cycle left-shift engine: one zero-fill shift per clock over a valid/ready handshake.
// Optional overflow flag output enabled by defining LSS_OVF_EN.
module left_shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef LSS_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      data      <= '0;
    end else if (abort) begin
      // abort overrides any handshake sampled on the same edge
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data     <= in_data;
            cnt      <= in_amt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            data <= {data[WIDTH-2:0], 1'b0};
            cnt  <= cnt - AMT_W'(1);
          end else begin
            out_valid <= 1'b1;
            out_data  <= data;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSS_OVF_EN
  logic ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf     <= 1'b0;
      out_ovf <= 1'b0;
    end else if (abort) begin
      ovf     <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (in_valid && in_ready) ovf <= 1'b0;
        SHIFT: begin
          if (cnt != '0) ovf <= ovf | data[WIDTH-1];
          else           out_ovf <= ovf;
        end
        DONE:    if (out_ready) out_ovf <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_left_shift_sequencer.sv
// Directed bench for left_shift_sequencer: hand-computed results, latencies, hold, abort and reset.
// Overflow-flag checks are included when LSS_OVF_EN is defined.
module tb_left_shift_sequencer;

  logic       clk;
  logic       reset_n;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef LSS_OVF_EN
  logic       out_ovf;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  left_shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef LSS_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for the result; checks latency and data.
  task automatic run_req(input string tag, input logic [7:0] d, input logic [2:0] a,
                         input logic [7:0] exp, input int unsigned exp_lat);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_amt   = 3'd0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
`ifdef LSS_OVF_EN
    chk({tag, "_hs_ovf"}, 32'(out_ovf), 32'd0);
`endif
  endtask

  initial begin
    reset_n   = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    out_ready = 1'b1;

    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef LSS_OVF_EN
    chk("rst_ovf", 32'(out_ovf), 32'd0);
`endif

    #2 reset_n = 1'b1;
    chk("post_rel_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("post_rel_ready", 32'(in_ready), 32'd1);

    run_req("a5_amt3", 8'hA5, 3'd3, 8'h28, 4);
`ifdef LSS_OVF_EN
    chk("a5_amt3_ovf", 32'(out_ovf), 32'd1);
`endif
    handshake("a5_amt3");

    run_req("01_amt0", 8'h01, 3'd0, 8'h01, 1);
`ifdef LSS_OVF_EN
    chk("01_amt0_ovf", 32'(out_ovf), 32'd0);
`endif
    handshake("01_amt0");

    run_req("01_amt7", 8'h01, 3'd7, 8'h80, 8);
`ifdef LSS_OVF_EN
    chk("01_amt7_ovf", 32'(out_ovf), 32'd0);
`endif
    handshake("01_amt7");

    // Result held while the consumer stalls
    out_ready = 1'b0;
    run_req("ff_amt2", 8'hFF, 3'd2, 8'hFC, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ff_hold_valid", 32'(out_valid), 32'd1);
      chk("ff_hold_data", 32'(out_data), 32'hFC);
`ifdef LSS_OVF_EN
      chk("ff_hold_ovf", 32'(out_ovf), 32'd1);
`endif
    end
    handshake("ff_amt2");

    // Abort mid-shift, then a fresh request
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_amt   = 3'd5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_data", 32'(out_data), 32'd0);
    repeat (6) tick();
    chk("abort_no_result", 32'(out_valid), 32'd0);
    run_req("0c_amt1", 8'h0C, 3'd1, 8'h18, 2);
    handshake("0c_amt1");

    // Abort wins over a same-edge accept
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_amt   = 3'd1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort_vs_accept_busy", 32'(busy), 32'd0);
    chk("abort_vs_accept_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset mid-shift
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_amt   = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    #2 reset_n = 1'b1;
    chk("midrst_rel_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_rel_ready", 32'(in_ready), 32'd1);
    run_req("3c_amt2", 8'h3C, 3'd2, 8'hF0, 3);
`ifdef LSS_OVF_EN
    chk("3c_amt2_ovf", 32'(out_ovf), 32'd0);
`endif
    handshake("3c_amt2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
